// File: rtl/enemy_missile_launcher_if.sv
// Interface bundling the enemy missile slot's control inputs and status outputs.
//   master: spawn pattern / tick / launch geometry / destroy source, receives missile status
//   slave : the missile slot itself
// Signals:
//   spawn_bit, frame_tick, start_x[XW], target_x[XW], destroy       master -> slave
//   missile_active, missile_x[XW], missile_y[YW], impact,
//   impact_x[XW], busy                                               slave -> master
interface enemy_missile_launcher_if #(
    parameter int XW = 10,
    parameter int YW = 9
) ();
    logic          spawn_bit;
    logic          frame_tick;
    logic [XW-1:0] start_x;
    logic [XW-1:0] target_x;
    logic          destroy;
    logic          missile_active;
    logic [XW-1:0] missile_x;
    logic [YW-1:0] missile_y;
    logic          impact;
    logic [XW-1:0] impact_x;
    logic          busy;

    modport master (
        output spawn_bit, frame_tick, start_x, target_x, destroy,
        input  missile_active, missile_x, missile_y, impact, impact_x, busy
    );

    modport slave (
        input  spawn_bit, frame_tick, start_x, target_x, destroy,
        output missile_active, missile_x, missile_y, impact, impact_x, busy
    );
endinterface

// File: rtl/enemy_missile_launcher.sv
// One enemy missile slot. A '1' on the serial spawn pattern (sampled on a frame tick while
// idle) launches a missile from a clamped top-of-screen x toward a ground target. The missile
// descends one pixel every STEP_DIV frame ticks, x following a Bresenham line whose major axis
// is the GROUND_Y descent. Reaching GROUND_Y pulses impact; a destroy request kills it silently.
// Either way the slot then waits COOLDOWN frame ticks before it can launch again.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      enemy_missile_launcher_if.slave (spawn/tick/geometry/destroy in, status out)
module enemy_missile_launcher #(
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int SCREEN_W = 640,
    parameter int GROUND_Y = 440,
    parameter int STEP_DIV = 4,
    parameter int COOLDOWN = 16
) (
    input logic                     clk,
    input logic                     reset_n,
    enemy_missile_launcher_if.slave bus
);

    localparam int ErrW  = YW + 1;
    localparam int DivW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int CoolW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic [XW-1:0]    XMax      = XW'(SCREEN_W - 1);
    localparam logic [XW-1:0]    DxMax     = XW'(GROUND_Y);
    localparam logic [YW-1:0]    YGround   = YW'(GROUND_Y);
    localparam logic [ErrW-1:0]  ErrGround = ErrW'(GROUND_Y);
    localparam logic [DivW-1:0]  DivLast   = DivW'(STEP_DIV - 1);
    localparam logic [CoolW-1:0] CoolLast  = CoolW'(COOLDOWN - 1);

    typedef enum logic [1:0] {StIdle, StFlying, StImpact, StCooldown} state_e;

    state_e           state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [ErrW-1:0]  err_q, err_d;
    logic [YW-1:0]    dx_q, dx_d;
    logic             dir_q, dir_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [CoolW-1:0] cool_q, cool_d;
    logic             active_q, active_d;
    logic             impact_q, impact_d;
    logic [XW-1:0]    impact_x_q, impact_x_d;
    logic             busy_q, busy_d;

    // Launch geometry, evaluated combinationally and only latched on a launch.
    logic [XW-1:0]   x0;
    logic            dir_l;
    logic [XW-1:0]   diff_l;
    logic [XW-1:0]   dx_l;
    logic [ErrW-1:0] err_sum;
    logic [YW-1:0]   y_inc;

    always_comb begin
        x0      = (bus.start_x > XMax) ? XMax : bus.start_x;
        dir_l   = (bus.target_x >= x0);
        diff_l  = dir_l ? (bus.target_x - x0) : (x0 - bus.target_x);
        dx_l    = (diff_l > DxMax) ? DxMax : diff_l;
        err_sum = err_q + {1'b0, dx_q};
        y_inc   = y_q + YW'(1);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        dx_d    = dx_q;
        dir_d   = dir_q;
        div_d   = div_q;
        cool_d  = cool_q;

        unique case (state_q)
            StIdle: begin
                if (bus.frame_tick && bus.spawn_bit) begin
                    x_d     = x0;
                    y_d     = '0;
                    err_d   = '0;
                    div_d   = '0;
                    dir_d   = dir_l;
                    dx_d    = YW'(dx_l);
                    state_d = StFlying;
                end
            end
            StFlying: begin
                // Destroy wins over any step, including the one that would reach the ground.
                if (bus.destroy) begin
                    cool_d  = '0;
                    state_d = StCooldown;
                end else if (bus.frame_tick) begin
                    if (div_q == DivLast) begin
                        div_d = '0;
                        y_d   = y_inc;
                        if (err_sum >= ErrGround) begin
                            err_d = err_sum - ErrGround;
                            x_d   = dir_q ? (x_q + XW'(1)) : (x_q - XW'(1));
                        end else begin
                            err_d = err_sum;
                        end
                        if (y_inc == YGround) begin
                            state_d = StImpact;
                        end
                    end else begin
                        div_d = div_q + DivW'(1);
                    end
                end
            end
            StImpact: begin
                cool_d  = '0;
                state_d = StCooldown;
            end
            StCooldown: begin
                if (bus.frame_tick) begin
                    if (cool_q == CoolLast) begin
                        state_d = StIdle;
                    end else begin
                        cool_d = cool_q + CoolW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered copies of the next state so they move with the state.
        active_d   = (state_d == StFlying);
        impact_d   = (state_d == StImpact);
        busy_d     = (state_d != StIdle);
        impact_x_d = (state_d == StImpact) ? x_d : impact_x_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            err_q      <= '0;
            dx_q       <= '0;
            dir_q      <= 1'b0;
            div_q      <= '0;
            cool_q     <= '0;
            active_q   <= 1'b0;
            impact_q   <= 1'b0;
            impact_x_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            err_q      <= err_d;
            dx_q       <= dx_d;
            dir_q      <= dir_d;
            div_q      <= div_d;
            cool_q     <= cool_d;
            active_q   <= active_d;
            impact_q   <= impact_d;
            impact_x_q <= impact_x_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.missile_active = active_q;
    assign bus.missile_x      = x_q;
    assign bus.missile_y      = y_q;
    assign bus.impact         = impact_q;
    assign bus.impact_x       = impact_x_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_enemy_missile_launcher.sv
// Directed bench for enemy_missile_launcher: one STEP_DIV=1 slot for the flight scenarios and a
// STEP_DIV=4 slot sharing the same inputs for the step divider.
module tb_enemy_missile_launcher;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    enemy_missile_launcher_if #(.XW(10), .YW(9)) bus ();
    enemy_missile_launcher_if #(.XW(10), .YW(9)) bus4 ();

    assign bus4.spawn_bit  = bus.spawn_bit;
    assign bus4.frame_tick = bus.frame_tick;
    assign bus4.start_x    = bus.start_x;
    assign bus4.target_x   = bus.target_x;
    assign bus4.destroy    = bus.destroy;

    enemy_missile_launcher #(
        .XW(10), .YW(9), .SCREEN_W(640), .GROUND_Y(440), .STEP_DIV(1), .COOLDOWN(16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    enemy_missile_launcher #(
        .XW(10), .YW(9), .SCREEN_W(640), .GROUND_Y(440), .STEP_DIV(4), .COOLDOWN(16)
    ) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks are entered and left at a falling edge.
    task automatic do_tick(input logic sp);
        bus.spawn_bit  = sp;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n        = 1'b0;
        bus.spawn_bit  = 1'b0;
        bus.frame_tick = 1'b0;
        bus.destroy    = 1'b0;
        bus.start_x    = '0;
        bus.target_x   = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic launch(input int sx, input int tx);
        bus.start_x  = 10'(sx);
        bus.target_x = 10'(tx);
        do_tick(1'b1);
        bus.spawn_bit = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.missile_active !== 1'b0 || bus.impact !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got busy=%b act=%b imp=%b want 0 0 0",
                     bus.busy, bus.missile_active, bus.impact);
        end
        n_cmp++;
        if (bus.missile_x !== 10'd0 || bus.missile_y !== 9'd0 || bus.impact_x !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_coords: got x=%0d y=%0d ix=%0d want 0 0 0",
                     bus.missile_x, bus.missile_y, bus.impact_x);
        end
        do_tick(1'b0);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL tick_without_spawn: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_straight();
        launch(100, 100);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.missile_active !== 1'b1 || bus.missile_x !== 10'd100 ||
            bus.missile_y !== 9'd0) begin
            n_bad++;
            $display("FAIL straight_launch: got busy=%b act=%b x=%0d y=%0d want 1 1 100 0",
                     bus.busy, bus.missile_active, bus.missile_x, bus.missile_y);
        end
        for (int i = 1; i <= 440; i++) begin
            do_tick(1'b0);
            n_cmp++;
            if (bus.missile_x !== 10'd100 || bus.missile_y !== 9'(i) ||
                bus.missile_active !== (i < 440) || bus.impact !== (i == 440)) begin
                n_bad++;
                $display("FAIL straight_step %0d: got x=%0d y=%0d act=%b imp=%b want 100 %0d %b %b",
                         i, bus.missile_x, bus.missile_y, bus.missile_active, bus.impact,
                         i, (i < 440), (i == 440));
            end
        end
        n_cmp++;
        if (bus.impact_x !== 10'd100) begin
            n_bad++;
            $display("FAIL straight_impact_x: got %0d want 100", bus.impact_x);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.impact !== 1'b0 || bus.impact_x !== 10'd100 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL straight_pulse_end: got imp=%b ix=%0d busy=%b want 0 100 1",
                     bus.impact, bus.impact_x, bus.busy);
        end
        for (int k = 1; k <= 16; k++) begin
            do_tick(1'b0);
            n_cmp++;
            if (bus.busy !== (k < 16)) begin
                n_bad++;
                $display("FAIL straight_cooldown tick %0d: got busy=%b want %b",
                         k, bus.busy, (k < 16));
            end
        end
    endtask

    task automatic test_async_reset();
        launch(320, 320);
        for (int i = 1; i <= 200; i++) do_tick(1'b0);
        n_cmp++;
        if (bus.missile_y !== 9'd200 || bus.impact_x !== 10'd100) begin
            n_bad++;
            $display("FAIL pre_reset: got y=%0d ix=%0d want 200 100",
                     bus.missile_y, bus.impact_x);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.missile_active !== 1'b0 || bus.busy !== 1'b0 || bus.impact !== 1'b0 ||
            bus.missile_x !== 10'd0 || bus.missile_y !== 9'd0 || bus.impact_x !== 10'd0) begin
            n_bad++;
            $display("FAIL async_reset: got act=%b busy=%b imp=%b x=%0d y=%0d ix=%0d want all 0",
                     bus.missile_active, bus.busy, bus.impact, bus.missile_x,
                     bus.missile_y, bus.impact_x);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            do_tick(1'b0);
            n_cmp++;
            if (bus.impact !== 1'b0 || bus.busy !== 1'b0 || bus.missile_active !== 1'b0) begin
                n_bad++;
                $display("FAIL post_reset tick %0d: got imp=%b busy=%b act=%b want 0 0 0",
                         k, bus.impact, bus.busy, bus.missile_active);
            end
        end
    endtask

    // Diagonal flight with spawn held high throughout: no relaunch until IDLE is reached.
    task automatic test_diagonal_spawn_hold();
        bus.start_x  = 10'd0;
        bus.target_x = 10'd440;
        do_tick(1'b1);
        for (int i = 1; i <= 440; i++) begin
            do_tick(1'b1);
            n_cmp++;
            if (bus.missile_x !== 10'(i) || bus.missile_y !== 9'(i)) begin
                n_bad++;
                $display("FAIL diag_step %0d: got x=%0d y=%0d want %0d %0d",
                         i, bus.missile_x, bus.missile_y, i, i);
            end
        end
        n_cmp++;
        if (bus.impact !== 1'b1 || bus.impact_x !== 10'd440) begin
            n_bad++;
            $display("FAIL diag_impact: got imp=%b ix=%0d want 1 440", bus.impact, bus.impact_x);
        end
        bus.spawn_bit = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            do_tick(1'b1);
            n_cmp++;
            if (bus.busy !== (k < 16) || bus.missile_active !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_cooldown tick %0d: got busy=%b act=%b want %b 0",
                         k, bus.busy, bus.missile_active, (k < 16));
            end
        end
        do_tick(1'b1);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.missile_active !== 1'b1 || bus.missile_y !== 9'd0 ||
            bus.missile_x !== 10'd0) begin
            n_bad++;
            $display("FAIL relaunch: got busy=%b act=%b x=%0d y=%0d want 1 1 0 0",
                     bus.busy, bus.missile_active, bus.missile_x, bus.missile_y);
        end
        apply_reset();
    endtask

    task automatic test_clamp();
        launch(700, 0);
        n_cmp++;
        if (bus.missile_x !== 10'd639) begin
            n_bad++;
            $display("FAIL clamp_x0: got %0d want 639", bus.missile_x);
        end
        for (int i = 1; i <= 440; i++) begin
            do_tick(1'b0);
            n_cmp++;
            if (bus.missile_x !== 10'(639 - i) || bus.missile_y !== 9'(i)) begin
                n_bad++;
                $display("FAIL clamp_step %0d: got x=%0d y=%0d want %0d %0d",
                         i, bus.missile_x, bus.missile_y, 639 - i, i);
            end
        end
        n_cmp++;
        if (bus.impact !== 1'b1 || bus.impact_x !== 10'd199) begin
            n_bad++;
            $display("FAIL clamp_impact: got imp=%b ix=%0d want 1 199", bus.impact, bus.impact_x);
        end
        apply_reset();
    endtask

    task automatic test_destroy();
        launch(300, 300);
        for (int i = 1; i <= 50; i++) do_tick(1'b0);
        bus.destroy = 1'b1;
        @(negedge clk);
        bus.destroy = 1'b0;
        n_cmp++;
        if (bus.missile_active !== 1'b0 || bus.busy !== 1'b1 || bus.impact !== 1'b0 ||
            bus.missile_y !== 9'd50 || bus.missile_x !== 10'd300) begin
            n_bad++;
            $display("FAIL destroy: got act=%b busy=%b imp=%b x=%0d y=%0d want 0 1 0 300 50",
                     bus.missile_active, bus.busy, bus.impact, bus.missile_x, bus.missile_y);
        end
        for (int k = 1; k <= 16; k++) begin
            do_tick(1'b0);
            n_cmp++;
            if (bus.busy !== (k < 16) || bus.impact !== 1'b0) begin
                n_bad++;
                $display("FAIL destroy_cooldown tick %0d: got busy=%b imp=%b want %b 0",
                         k, bus.busy, bus.impact, (k < 16));
            end
        end
    endtask

    task automatic test_destroy_final_step();
        launch(10, 10);
        for (int i = 1; i <= 439; i++) do_tick(1'b0);
        bus.destroy = 1'b1;
        do_tick(1'b0);
        bus.destroy = 1'b0;
        n_cmp++;
        if (bus.impact !== 1'b0 || bus.missile_active !== 1'b0 || bus.busy !== 1'b1 ||
            bus.missile_y !== 9'd439) begin
            n_bad++;
            $display("FAIL destroy_final: got imp=%b act=%b busy=%b y=%0d want 0 0 1 439",
                     bus.impact, bus.missile_active, bus.busy, bus.missile_y);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.impact !== 1'b0 || bus.impact_x !== 10'd0) begin
            n_bad++;
            $display("FAIL destroy_final_late: got imp=%b ix=%0d want 0 0",
                     bus.impact, bus.impact_x);
        end
        apply_reset();
    endtask

    task automatic test_divider();
        launch(50, 50);
        for (int i = 1; i <= 9; i++) begin
            do_tick(1'b0);
            n_cmp++;
            if (bus4.missile_y !== 9'(i / 4) || bus4.missile_active !== 1'b1) begin
                n_bad++;
                $display("FAIL divider tick %0d: got y=%0d act=%b want %0d 1",
                         i, bus4.missile_y, bus4.missile_active, i / 4);
            end
        end
        apply_reset();
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        reset_n        = 1'b0;
        bus.spawn_bit  = 1'b0;
        bus.frame_tick = 1'b0;
        bus.destroy    = 1'b0;
        bus.start_x    = '0;
        bus.target_x   = '0;
        @(negedge clk);
        test_reset();
        test_straight();
        test_async_reset();
        test_diagonal_spawn_hold();
        test_clamp();
        test_destroy();
        test_destroy_final_step();
        test_divider();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
